// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: drives the PC register input, runs the imem
// req/ack handshake, buffers fetched words in a 2-entry FIFO and handles redirects.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          INST_BYTES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  typedef enum logic {S_RUN, S_DROP} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [31:0] addr_hold_q, addr_hold_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] inst_q [2];
  logic [31:0] ipc_q  [2];

  logic        issue;
  logic        push;
  logic        pop;
  logic [31:0] pc_word;
  logic        align_bits_unused;

  // Addresses are word aligned; the low bits of pc and redirect_pc carry no information.
  assign pc_word           = {pc[31:2], 2'b00};
  assign align_bits_unused = ^{pc[1:0], redirect_pc[1:0]};

  always_comb begin
    // A redirect makes the current pc stale, so no fresh request is started then.
    issue     = !reset && !redirect && (state_q == S_RUN) && !busy_q &&
                ((count_q + {1'b0, busy_q}) < 2'd2);
    imem_req  = !reset && (busy_q || issue);
    imem_addr = busy_q ? addr_hold_q : pc_word;
    push      = (state_q == S_RUN) && imem_req && imem_ack && !redirect;
    out_valid = !reset && (count_q != 2'd0);
    pop       = out_valid && out_ready && !redirect;
    out_inst  = inst_q[rd_ptr_q];
    out_pc    = ipc_q[rd_ptr_q];

    if (reset) begin
      npc = {RESET_PC[31:2], 2'b00};
    end else if (redirect) begin
      npc = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      npc = pc_word + 32'(INST_BYTES);
    end else begin
      npc = pc_word;
    end

    state_d     = state_q;
    busy_d      = busy_q;
    addr_hold_d = addr_hold_q;
    if (issue) begin
      addr_hold_d = pc_word;
    end
    if (imem_req && imem_ack) begin
      busy_d  = 1'b0;
      state_d = S_RUN;
    end else if (imem_req) begin
      busy_d = 1'b1;
      if (redirect) begin
        state_d = S_DROP;
      end
    end

    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    if (redirect) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_RUN;
      busy_q      <= 1'b0;
      addr_hold_q <= RESET_PC;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      addr_hold_q <= addr_hold_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // FIFO storage needs no reset: count_q alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_q[wr_ptr_q] <= imem_rdata;
      ipc_q[wr_ptr_q]  <= imem_addr;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a PC register model, a variable-latency
// memory model and a scoreboard of expected FIFO words.
module tb_ifetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int vectors = 0;
  int errors  = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;

  logic [63:0] sb_q [$];
  logic        drop_m = 1'b0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  ifetch_ctrl dut (
    .clock(clock), .reset(reset), .pc(pc), .npc(npc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // PC register and memory model
  always @(posedge clock) pc <= npc;
  always @(posedge clock) wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
  assign imem_ack   = imem_req && (wait_cnt == ack_delay);
  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Scoreboard and handshake-stability monitor
  always @(negedge clock) begin
    logic [63:0] head;
    chk("out_valid_vs_sb", {31'b0, out_valid}, {31'b0, (sb_q.size() != 0) && !reset});
    if (!reset && prev_pend) begin
      chk("req_held", {31'b0, imem_req}, 32'h1);
      chk("addr_held", imem_addr, prev_addr);
    end
    if (reset) begin
      sb_q.delete();
      drop_m = 1'b0;
    end else begin
      if (out_valid && out_ready && !redirect && sb_q.size() != 0) begin
        head = sb_q.pop_front();
        chk("pop_inst", out_inst, head[63:32]);
        chk("pop_pc", out_pc, head[31:0]);
      end
      if (redirect) begin
        sb_q.delete();
        if (imem_req && !imem_ack) drop_m = 1'b1;
        else if (imem_req) drop_m = 1'b0;
      end else if (imem_req && imem_ack) begin
        if (drop_m) drop_m = 1'b0;
        else sb_q.push_back({mem_word(pc), pc});
      end
    end
    prev_pend = !reset && imem_req && !imem_ack;
    prev_addr = imem_addr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    step();
    @(negedge clock);
    chk("rst_npc", npc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    step();
    reset = 1'b0;

    // zero-wait streaming
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("t1_pc", pc, 32'(4 * k));
      chk("t1_addr", imem_addr, 32'(4 * k));
      chk("t1_npc", npc, 32'(4 * k + 4));
      step();
    end

    // three wait states on the request at 24
    ack_delay = 3;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      chk("t2_req", {31'b0, imem_req}, 32'h1);
      chk("t2_addr", imem_addr, 32'd24);
      chk("t2_npc", npc, (j < 3) ? 32'd24 : 32'd28);
      step();
    end

    // back-pressure: restart at 0 with decode stalled
    ack_delay = 0; out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
    @(negedge clock);
    chk("t3_redir_npc", npc, 32'h0);
    step();
    redirect = 1'b0;
    @(negedge clock); chk("t3_npc_a", npc, 32'd4); step();
    @(negedge clock); chk("t3_npc_b", npc, 32'd8); step();
    for (int j = 0; j < 2; j++) begin
      @(negedge clock);
      chk("t3_req_stall", {31'b0, imem_req}, 32'h0);
      chk("t3_pc_hold", pc, 32'd8);
      chk("t3_npc_hold", npc, 32'd8);
      step();
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("t3_head_pc", out_pc, 32'd0);
    chk("t3_no_issue_full", {31'b0, imem_req}, 32'h0);
    step();
    @(negedge clock);
    chk("t3_resume_req", {31'b0, imem_req}, 32'h1);
    chk("t3_resume_addr", imem_addr, 32'd8);
    step();

    // redirect with two buffered words
    out_ready = 1'b0;
    @(negedge clock); chk("t4_addr", imem_addr, 32'd12); step();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clock);
    chk("t4_npc", npc, 32'h0000_0100);
    chk("t4_valid_before", {31'b0, out_valid}, 32'h1);
    step();
    redirect = 1'b0;
    @(negedge clock);
    chk("t4_flushed", {31'b0, out_valid}, 32'h0);
    chk("t4_pc", pc, 32'h100);
    chk("t4_fetch_addr", imem_addr, 32'h100);
    step();

    // redirect while a request is outstanding
    out_ready = 1'b1; ack_delay = 3;
    @(negedge clock); chk("t5_addr", imem_addr, 32'h104); step();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clock); chk("t5_redir_npc", npc, 32'h200); step();
    redirect = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clock);
      chk("t5_drop_addr", imem_addr, 32'h104);
      chk("t5_drop_npc", npc, 32'h200);
      step();
    end
    ack_delay = 0;
    @(negedge clock);
    chk("t5_target_addr", imem_addr, 32'h200);
    chk("t5_no_stale", {31'b0, out_valid}, 32'h0);
    chk("t5_target_npc", npc, 32'h204);
    step();

    // wrap-around, then reset during a waiting request
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clock); step();
    redirect = 1'b0;
    @(negedge clock);
    chk("t6_pc", pc, 32'hFFFF_FFFC);
    chk("t6_wrap_npc", npc, 32'h0);
    step();
    ack_delay = 3;
    @(negedge clock); chk("t6_wait_req", {31'b0, imem_req}, 32'h1); step();
    reset = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clock);
      chk("t6_rst_req", {31'b0, imem_req}, 32'h0);
      chk("t6_rst_valid", {31'b0, out_valid}, 32'h0);
      chk("t6_rst_npc", npc, 32'h0);
      step();
    end
    reset = 1'b0; ack_delay = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t6_restart_pc", pc, 32'(4 * k));
      step();
    end
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
